// File: rtl/case_seq_pkg.sv
// Shared types and decode constants for the case_seq_ctrl select sequencer.
package case_seq_pkg;

    localparam int CSEQ_HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]             sel;
        logic [CSEQ_HOLD_W-1:0] hold;
    } entry_t;

    localparam logic [3:0] K_000 = 4'd1;
    localparam logic [3:0] K_001 = 4'd2;
    localparam logic [3:0] K_101 = 4'd1;
    localparam logic [3:0] K_DEF = 4'd5;

endpackage

// File: rtl/case_decode.sv
// Fixed combinational select-to-code decoder.
module case_decode
    import case_seq_pkg::*;
(
    input  logic [2:0] sel_i,
    output logic [3:0] k_o
);

    always_comb begin
        case (sel_i)
            3'b000:  k_o = K_000;
            3'b001:  k_o = K_001;
            3'b101:  k_o = K_101;
            default: k_o = K_DEF;
        endcase
    end

endmodule

// File: rtl/case_seq_ctrl.sv
// Table-driven select sequencer with per-entry hold, registered decode and checksum.
// Optional continuous looping over the table when CASE_SEQ_LOOP_EN is defined.
module case_seq_ctrl
    import case_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int HOLD_W = CSEQ_HOLD_W,
    parameter int SUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [2:0]        cfg_sel,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic [AW:0]       cfg_len,
`ifdef CASE_SEQ_LOOP_EN
    input  logic              cfg_loop,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2:0]        sel_out,
    output logic [3:0]        k_out,
    output logic              k_valid,
    output logic [SUM_W-1:0]  sum_out
);

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [AW:0]       len_q, len_d;
    logic [2:0]        sel_q, sel_d;
    logic [3:0]        k_q, k_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              done_q, done_d;
    entry_t            tbl_q [DEPTH];

    logic [3:0]        k_dec;
    logic [AW:0]       len_sat;
    logic              last_entry;
    logic              hold_end;
    logic              loop_on;

    case_decode u_decode (
        .sel_i (sel_q),
        .k_o   (k_dec)
    );

`ifdef CASE_SEQ_LOOP_EN
    assign loop_on = cfg_loop;
`else
    assign loop_on = 1'b0;
`endif

    assign len_sat    = (cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_len;
    assign last_entry = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
    assign hold_end   = (state_q == HOLD) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (len_sat != '0)) state_d = APPLY;
            APPLY:   state_d = HOLD;
            HOLD:    if (cnt_q == '0) state_d = (last_entry && !loop_on) ? DONE : APPLY;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE) || done_q;
        k_valid = hold_end;
    end

    // Datapath next-state: table fetch, hold countdown, decode capture and checksum.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        sel_d  = sel_q;
        k_d    = k_q;
        sum_d  = sum_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sum_d = '0;
                    if (len_sat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d = len_sat;
                        idx_d = '0;
                    end
                end
            end
            APPLY: begin
                sel_d = tbl_q[idx_q].sel;
                cnt_d = HOLD_W'(tbl_q[idx_q].hold);
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end else begin
                    k_d   = k_dec;
                    sum_d = sum_q + SUM_W'(k_dec);
                    if (!last_entry) begin
                        idx_d = idx_q + AW'(1);
                    end else if (loop_on) begin
                        idx_d  = '0;
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            sel_q  <= '0;
            k_q    <= '0;
            sum_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            sel_q  <= sel_d;
            k_q    <= k_d;
            sum_q  <= sum_d;
            done_q <= done_d;
        end
    end

    // Table writes are locked out for the whole run, including the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (cfg_we && !busy) begin
            tbl_q[cfg_addr] <= '{sel: cfg_sel, hold: CSEQ_HOLD_W'(cfg_hold)};
        end
    end

    assign sel_out = sel_q;
    assign k_out   = k_q;
    assign sum_out = sum_q;

endmodule

// File: doc/case_seq_ctrl.md
Name: case_seq_ctrl

Overview:
Sequencer that drives a 3-bit select into the select-to-code decoder and holds each select for a programmed number of cycles. It registers the decoded 4-bit code and accumulates a running checksum. The sequence is a small table loaded through a config write port. Start/busy/done handshake. Sits between the test/config master and the decode datapath; it lets the select pattern run under clock control instead of from a timed initial block.

Parameters:
DEPTH, 8, number of sequence table entries (power of two, ≥2)
AW, 3, table address width, equal to log2(DEPTH)
HOLD_W, 4, width of the per-entry hold count
SUM_W, 8, checksum width; wraps modulo 2^SUM_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  table write strobe; ignored while busy
cfg_addr  in  AW  table write address
cfg_sel  in  3  select value to store
cfg_hold  in  HOLD_W  extra hold cycles for the entry
cfg_len  in  AW+1  number of entries to run (0..DEPTH); sampled on start
start  in  1  one-cycle start pulse; ignored unless IDLE
busy  out  1  high from the first cycle after accepted start through the DONE cycle
done  out  1  one-cycle completion pulse
sel_out  out  3  select currently driven to the decoder
k_out  out  4  registered decoded code
k_valid  out  1  one-cycle strobe; k_out is valid for the entry just finished
sum_out  out  SUM_W  running sum of k_out values this run

Behaviour:
- Decode map, fixed, in sub-module: 000→1, 001→2, 101→1, all other selects→5. Pure combinational; 4-bit output.
- Reset: state=IDLE. busy, done, k_valid, sel_out, k_out and sum_out are 0. idx and cnt are 0. All table entries clear to {sel=0, hold=0}.
- Table write: on the cfg_we edge, only when not busy: table[cfg_addr] <= {cfg_sel, cfg_hold}. A write during a run is dropped silently.
- IDLE:
  - start with cfg_len≠0: latch len, set idx=0, clear sum_out to 0, go to APPLY.
  - start with cfg_len=0: done pulses next cycle, busy stays 0, sum_out clears to 0, state stays IDLE.
  - cfg_len>DEPTH is saturated to DEPTH.
- APPLY, 1 cycle: sel_out<=table[idx].sel, cnt<=table[idx].hold, go to HOLD.
- HOLD:
  - while cnt≠0: cnt decrements.
  - at cnt=0: k_out<=decode(sel_out), k_valid=1, sum_out<=sum_out+zero-extended decode(sel_out) (wraps).
  - then, if idx=len-1, go to DONE; otherwise idx++ and go to APPLY.
- Cycles per entry: 2+hold.
- DONE, 1 cycle: done=1, busy=1, then go to IDLE. sel_out, k_out and sum_out hold their last values until the next start.
- start while busy is ignored.
- Async reset mid-run: immediate return to the reset values. The table is also cleared.

Optional Feature:
- Macro: CASE_SEQ_LOOP_EN.
- With the macro defined:
  - extra input port cfg_loop (1 bit), sampled at each end of pass.
  - if cfg_loop=1 when the last entry's k_valid fires: done pulses for one cycle, idx wraps to 0, and the next state is APPLY. There is no DONE state, busy stays 1, and sum_out keeps accumulating.
  - deasserting cfg_loop ends the run after the current pass through the normal DONE state.
- Without the macro: the port is absent and every run is a single pass.

Decomposition:
- Package case_seq_pkg holds:
  - the state enum {IDLE, APPLY, HOLD, DONE};
  - the entry struct {sel[2:0], hold[HOLD_W-1:0]};
  - decode constants K_000=1, K_001=2, K_101=1, K_DEF=5.
- One sub-module, case_decode: combinational 3→4 decoder, instanced once in the controller.

Test Plan:
- Reset check: assert rst for 3 cycles mid-stream → all outputs are 0 and the state is IDLE. After release, a run with len=1 on a cleared table gives k_out=1 and sum_out=1.
- Basic sequence: table {000,h0},{001,h2},{101,h0},{110,h1}, len=4, start → k_valid values 1,2,1,5 at 2, 6, 8 and 11 cycles after start. sum_out=9. done pulses 12 cycles after start. busy is high for cycles 1..12.
- Zero length: cfg_len=0, start → done 1 cycle later, busy never rises, k_valid never fires.
- Interference: cfg_we to entry 0 (sel=111) and a second start during a run → ignored. The run's results are unchanged, and table[0] reads back as 000 on the next run (k=1).
- Checksum wrap: 8 entries of sel=111 with SUM_W=4 → sum_out=(8×5) mod 16=8.
- Loop mode (CASE_SEQ_LOOP_EN): len=2 with {001,h0},{101,h0}, cfg_loop=1 → done pulses every 4 cycles, busy stays high, and sum_out goes 3, 6, 9. Clear cfg_loop → the run finishes after the current pass via DONE, then busy falls.
